// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache request port between NUM_REQ
// requesters, with one buffer per requester and tagged response routing.
module cache_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 3,
    localparam int IDX_W  = $clog2(NUM_REQ),
    localparam int CID_W  = IDX_W + ID_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_rw_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ID_W-1:0]   req_id_i,
    output logic [NUM_REQ-1:0]        req_stall_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [ADDR_W-1:0]         cache_addr_o,
    output logic [DATA_W-1:0]         cache_data_o,
    output logic                      cache_rw_o,
    output logic                      cache_valid_o,
    output logic [CID_W-1:0]          cache_id_o,
    input  logic                      cache_stall_i,
    input  logic [DATA_W-1:0]         cache_data_i,
    input  logic [CID_W-1:0]          cache_id_i,
    input  logic                      cache_ready_i
);

    logic [NUM_REQ-1:0] buf_full;
    logic [ADDR_W-1:0]  buf_addr [NUM_REQ];
    logic [DATA_W-1:0]  buf_data [NUM_REQ];
    logic               buf_rw   [NUM_REQ];
    logic [ID_W-1:0]    buf_id   [NUM_REQ];

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               slot_free;
    logic               load;
    logic [IDX_W-1:0]   rsp_idx;
    logic [NUM_REQ-1:0] rsp_onehot;

    assign req_stall_o = buf_full;
    assign slot_free   = ~cache_valid_o | ~cache_stall_i;
    assign load        = grant_any & slot_free;
    assign rsp_idx     = cache_id_i[CID_W-1:ID_W];

    // First full buffer at or after rr_ptr, wrapping around.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (buf_full[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // One-hot response target; out-of-range indices are dropped.
    always_comb begin
        rsp_onehot = '0;
        if (int'(rsp_idx) < NUM_REQ)
            rsp_onehot = NUM_REQ'(1) << rsp_idx;
    end

    // Per-requester buffers: drain on grant, else capture when empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_full <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_addr[i] <= '0;
                buf_data[i] <= '0;
                buf_rw[i]   <= 1'b0;
                buf_id[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (load && grant_idx == IDX_W'(i)) begin
                    buf_full[i] <= 1'b0;
                end else if (req_valid_i[i] && !buf_full[i]) begin
                    buf_full[i] <= 1'b1;
                    buf_addr[i] <= req_addr_i[i*ADDR_W +: ADDR_W];
                    buf_data[i] <= req_data_i[i*DATA_W +: DATA_W];
                    buf_rw[i]   <= req_rw_i[i];
                    buf_id[i]   <= req_id_i[i*ID_W +: ID_W];
                end
            end
        end
    end

    // Issue slot: reload on grant, empty after acceptance, hold on stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cache_valid_o <= 1'b0;
            cache_addr_o  <= '0;
            cache_data_o  <= '0;
            cache_rw_o    <= 1'b0;
            cache_id_o    <= '0;
            rr_ptr        <= '0;
        end else if (load) begin
            cache_valid_o <= 1'b1;
            cache_addr_o  <= buf_addr[grant_idx];
            cache_data_o  <= buf_data[grant_idx];
            cache_rw_o    <= buf_rw[grant_idx];
            cache_id_o    <= {grant_idx, buf_id[grant_idx]};
            if (grant_idx == IDX_W'(NUM_REQ - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= grant_idx + 1'b1;
        end else if (cache_valid_o && !cache_stall_i) begin
            cache_valid_o <= 1'b0;
        end
    end

    // Register cache responses and steer them to the issuing requester.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            rsp_id_o    <= '0;
        end else begin
            rsp_valid_o <= '0;
            if (cache_ready_i) begin
                rsp_valid_o <= rsp_onehot;
                rsp_data_o  <= cache_data_i;
                rsp_id_o    <= cache_id_i[ID_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: directed scenarios plus
// randomized traffic compared against a transaction-level model.
module tb_cache_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int XW = 1;
    localparam int CW = XW + IW;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N*AW-1:0] req_addr_i = '0;
    logic [N*DW-1:0] req_data_i = '0;
    logic [N-1:0]    req_rw_i = '0;
    logic [N-1:0]    req_valid_i = '0;
    logic [N*IW-1:0] req_id_i = '0;
    logic [N-1:0]    req_stall_o;
    logic [DW-1:0]   rsp_data_o;
    logic [IW-1:0]   rsp_id_o;
    logic [N-1:0]    rsp_valid_o;
    logic [AW-1:0]   cache_addr_o;
    logic [DW-1:0]   cache_data_o;
    logic            cache_rw_o;
    logic            cache_valid_o;
    logic [CW-1:0]   cache_id_o;
    logic            cache_stall_i = 1'b0;
    logic [DW-1:0]   cache_data_i = '0;
    logic [CW-1:0]   cache_id_i = '0;
    logic            cache_ready_i = 1'b0;

    cache_port_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_rw_i(req_rw_i), .req_valid_i(req_valid_i),
        .req_id_i(req_id_i), .req_stall_o(req_stall_o),
        .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o),
        .rsp_valid_o(rsp_valid_o),
        .cache_addr_o(cache_addr_o), .cache_data_o(cache_data_o),
        .cache_rw_o(cache_rw_o), .cache_valid_o(cache_valid_o),
        .cache_id_o(cache_id_o), .cache_stall_i(cache_stall_i),
        .cache_data_i(cache_data_i), .cache_id_i(cache_id_i),
        .cache_ready_i(cache_ready_i)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: pending request per requester, one in-flight slot,
    // a round-robin pointer and the last routed response.
    logic [N-1:0]  m_pend;
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N];
    logic          m_rw   [N];
    logic [IW-1:0] m_id   [N];
    logic          s_v;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic          s_rw;
    logic [CW-1:0] s_id;
    int            ptr;
    logic [N-1:0]  r_v;
    logic [DW-1:0] r_data;
    logic [IW-1:0] r_id;
    int            grants[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        m_pend = '0;
        s_v = 1'b0;
        ptr = 0;
        r_v = '0;
        grants.delete();
    endtask

    task automatic compare();
        chk("req_stall_o", req_stall_o, m_pend);
        chk("cache_valid_o", cache_valid_o, s_v);
        if (s_v) begin
            chk("cache_addr_o", cache_addr_o, s_addr);
            chk("cache_data_o", cache_data_o, s_data);
            chk("cache_rw_o", cache_rw_o, s_rw);
            chk("cache_id_o", cache_id_o, s_id);
        end
        chk("rsp_valid_o", rsp_valid_o, r_v);
        if (r_v != 0) begin
            chk("rsp_data_o", rsp_data_o, r_data);
            chk("rsp_id_o", rsp_id_o, r_id);
        end
    endtask

    // Advance the model by one clock using the current inputs,
    // then let the DUT take the same edge and compare.
    task automatic step();
        bit acc, can, ld;
        int w, idx;
        logic [XW-1:0] wx;
        acc = s_v && !cache_stall_i;
        can = !s_v || acc;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int j = (ptr + k) % N;
            if (w < 0 && m_pend[j]) w = j;
        end
        ld = can && (w >= 0);
        if (ld) begin
            wx = XW'(w);
            s_v = 1'b1;
            s_addr = m_addr[w];
            s_data = m_data[w];
            s_rw = m_rw[w];
            s_id = {wx, m_id[w]};
            ptr = (w + 1) % N;
            grants.push_back(w);
        end else if (acc) begin
            s_v = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (ld && w == i) begin
                m_pend[i] = 1'b0;
            end else if (!m_pend[i] && req_valid_i[i]) begin
                m_pend[i] = 1'b1;
                m_addr[i] = req_addr_i[i*AW +: AW];
                m_data[i] = req_data_i[i*DW +: DW];
                m_rw[i] = req_rw_i[i];
                m_id[i] = req_id_i[i*IW +: IW];
            end
        end
        r_v = '0;
        if (cache_ready_i) begin
            idx = int'(cache_id_i[CW-1:IW]);
            if (idx < N) r_v[idx] = 1'b1;
            r_data = cache_data_i;
            r_id = cache_id_i[IW-1:0];
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_req(int i, logic [AW-1:0] a, logic [DW-1:0] d,
                           logic rw, logic [IW-1:0] id);
        req_addr_i[i*AW +: AW] = a;
        req_data_i[i*DW +: DW] = d;
        req_rw_i[i] = rw;
        req_id_i[i*IW +: IW] = id;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid_i = '0;
        cache_stall_i = 1'b0;
        cache_ready_i = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_stall_o", req_stall_o, 0);
        chk("rst cache_valid_o", cache_valid_o, 0);
        chk("rst cache_addr_o", cache_addr_o, 0);
        chk("rst cache_data_o", cache_data_o, 0);
        chk("rst cache_rw_o", cache_rw_o, 0);
        chk("rst cache_id_o", cache_id_o, 0);
        chk("rst rsp_valid_o", rsp_valid_o, 0);
        chk("rst rsp_data_o", rsp_data_o, 0);
        chk("rst rsp_id_o", rsp_id_o, 0);
        reset = 1'b1;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            if (!(req_valid_i[i] && m_pend[i])) begin
                req_valid_i[i] = 1'($urandom_range(0, 1));
                set_req(i, $urandom, $urandom,
                        1'($urandom_range(0, 1)),
                        IW'($urandom_range(0, 7)));
            end
        end
        cache_stall_i = ($urandom_range(0, 3) == 0);
        cache_ready_i = 1'($urandom_range(0, 1));
        cache_id_i = CW'($urandom_range(0, 15));
        cache_data_i = $urandom;
    endtask

    initial begin
        int g[$];
        int last[N];
        int gap, maxgap;

        // Single request and its response.
        do_reset();
        set_req(0, 97, 0, 1'b0, 2);
        req_valid_i = 2'b01;
        step();
        chk("t1 stall after capture", req_stall_o, 2'b01);
        req_valid_i = '0;
        step();
        chk("t1 cache_valid_o", cache_valid_o, 1);
        chk("t1 cache_id_o", cache_id_o, 4'h2);
        chk("t1 cache_addr_o", cache_addr_o, 97);
        cache_ready_i = 1'b1;
        cache_id_i = 4'h2;
        cache_data_i = 8;
        step();
        cache_ready_i = 1'b0;
        chk("t1 rsp_valid_o", rsp_valid_o, 2'b01);
        chk("t1 rsp_id_o", rsp_id_o, 2);
        chk("t1 rsp_data_o", rsp_data_o, 8);
        chk("t1 slot drained", cache_valid_o, 0);

        // Contention from rr_ptr = 0.
        do_reset();
        set_req(0, 101, 32'h55, 1'b1, 6);
        set_req(1, 201, 32'h66, 1'b0, 5);
        req_valid_i = 2'b11;
        step();
        req_valid_i = '0;
        step();
        chk("t2 first id", cache_id_o, 4'h6);
        chk("t2 first rw", cache_rw_o, 1);
        chk("t2 first addr", cache_addr_o, 101);
        step();
        chk("t2 second id", cache_id_o, 4'hD);
        chk("t2 second addr", cache_addr_o, 201);
        chk("t2 model ptr", ptr, 0);
        chk("t2 dut rr_ptr", dut.rr_ptr, 0);
        step();
        chk("t2 idle", cache_valid_o, 0);

        // Cache stall holds the slot; R1 waits in its buffer.
        do_reset();
        cache_stall_i = 1'b1;
        set_req(0, 65733, 7, 1'b0, 4);
        req_valid_i = 2'b01;
        step();
        set_req(1, 300, 9, 1'b0, 1);
        req_valid_i = 2'b10;
        step();
        req_valid_i = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t3 stall addr", cache_addr_o, 65733);
            chk("t3 stall valid", cache_valid_o, 1);
            chk("t3 r1 stall", req_stall_o[1], 1);
        end
        cache_stall_i = 1'b0;
        step();
        chk("t3 r1 issued addr", cache_addr_o, 300);
        chk("t3 r1 issued id", cache_id_o, 4'h9);
        step();
        chk("t3 idle", cache_valid_o, 0);

        // Fairness with both requesters always valid.
        do_reset();
        req_valid_i = 2'b11;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++)
                if (!m_pend[i])
                    set_req(i, $urandom, $urandom, 1'b0,
                            IW'($urandom_range(0, 7)));
            step();
            if (cache_valid_o) g.push_back(int'(cache_id_o[CW-1:IW]));
        end
        req_valid_i = '0;
        chk("t4 grant count", (g.size() >= 8), 1);
        maxgap = 0;
        for (int i = 0; i < N; i++) last[i] = -1;
        for (int k = 0; k < 8 && k < g.size(); k++) begin
            chk("t4 grant order", g[k], k % 2);
            gap = k - last[g[k]];
            if (gap > maxgap) maxgap = gap;
            last[g[k]] = k;
        end
        chk("t4 max wait", (maxgap <= 2), 1);
        chk("t4 model order", (grants.size() >= 2 &&
            grants[0] == 0 && grants[1] == 1), 1);

        // Response routing to requester 1.
        step();
        step();
        cache_ready_i = 1'b1;
        cache_id_i = 4'hB;
        cache_data_i = 1234;
        step();
        cache_ready_i = 1'b0;
        chk("t5 rsp_valid_o", rsp_valid_o, 2'b10);
        chk("t5 rsp_id_o", rsp_id_o, 3);
        chk("t5 rsp_data_o", rsp_data_o, 1234);

        // Reset while both buffers and the slot are full.
        do_reset();
        cache_stall_i = 1'b1;
        set_req(0, 11, 1, 1'b0, 1);
        set_req(1, 22, 2, 1'b1, 2);
        req_valid_i = 2'b11;
        step();
        req_valid_i = 2'b01;
        set_req(0, 33, 3, 1'b0, 3);
        step();
        step();
        chk("t6 model full", {s_v, m_pend}, 3'b111);
        chk("t6 dut full", {cache_valid_o, req_stall_o}, 3'b111);
        req_valid_i = '0;
        reset = 1'b0;
        #1;
        chk("t6 async valid", cache_valid_o, 0);
        chk("t6 async stall", req_stall_o, 0);
        model_clear();
        #1;
        reset = 1'b1;
        cache_stall_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6 no issue", cache_valid_o, 0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rand_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
